// File: rtl/ocl_adder_fifo_bridge.sv
// OCL register slave that pushes host operand pairs through a registered add/sub stage
// into a result FIFO, and serves result pops, status, control, hello-world and VLED reads.
module ocl_adder_fifo_bridge #(
    parameter int unsigned OPND_W      = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] ADDR_HELLO  = 32'h0000_0500,
    parameter logic [31:0] ADDR_VLED   = 32'h0000_0504,
    parameter logic [31:0] ADDR_OPND   = 32'h0000_0510,
    parameter logic [31:0] ADDR_RESULT = 32'h0000_0514,
    parameter logic [31:0] ADDR_STATUS = 32'h0000_0518,
    parameter logic [31:0] ADDR_CTRL   = 32'h0000_051C,
    parameter logic [31:0] UNIMPL_VAL  = 32'hDEAD_BEEF,
    parameter logic [31:0] EMPTY_VAL   = 32'hDEAD_0000
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n_sync,
    input  logic [31:0] wr_addr,
    input  logic        wready,
    input  logic [31:0] wdata,
    input  logic        arvalid_q,
    input  logic [31:0] araddr_q,
    input  logic        rready,
    input  logic [15:0] vled_q,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [31:0] hello_world_q
);

    localparam int unsigned RES_W = OPND_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic wr_hello, wr_opnd, wr_ctrl, flush, ovf_clr;
    logic mode, ovf;
    logic [OPND_W-1:0] a1, b1;
    logic m1, v1, v2;
    logic [RES_W-1:0] r2;
    logic [RES_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic empty, full, rd_fire, pop, push, ovf_set;
    logic [31:0] rd_word;

    assign wr_hello = wready && (wr_addr == ADDR_HELLO);
    assign wr_opnd  = wready && (wr_addr == ADDR_OPND);
    assign wr_ctrl  = wready && (wr_addr == ADDR_CTRL);
    assign flush    = wr_ctrl && wdata[2];
    assign ovf_clr  = wr_ctrl && wdata[1];

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    // Read handshake: a request is captured only while rvalid is low; rvalid/rdata then
    // hold until rvalid&rready, and any arvalid_q seen while rvalid is high is ignored.
    assign rd_fire = arvalid_q && !rvalid;
    assign pop     = rd_fire && (araddr_q == ADDR_RESULT) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = v2 && (!full || pop);
    assign ovf_set = v2 && full && !pop;
    assign rresp   = 2'b00;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            hello_world_q <= '0;
            mode          <= 1'b0;
            ovf           <= 1'b0;
            a1            <= '0;
            b1            <= '0;
            m1            <= 1'b0;
            v1            <= 1'b0;
            r2            <= '0;
            v2            <= 1'b0;
        end else begin
            if (wr_hello) hello_world_q <= wdata;
            if (wr_ctrl)  mode <= wdata[0];
            if (!flush && ovf_set) ovf <= 1'b1;
            else if (ovf_clr)      ovf <= 1'b0;
            // Mode is captured with the operands so later CTRL writes cannot alter them.
            v1 <= wr_opnd;
            if (wr_opnd) begin
                a1 <= wdata[OPND_W-1:0];
                b1 <= wdata[2*OPND_W-1:OPND_W];
                m1 <= mode;
            end
            v2 <= v1;
            if (v1) r2 <= m1 ? ({1'b0, a1} - {1'b0, b1}) : ({1'b0, a1} + {1'b0, b1});
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (push && !flush) mem[wr_ptr] <= r2;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_comb begin
        rd_word = UNIMPL_VAL;
        case (araddr_q)
            ADDR_RESULT: rd_word = empty ? EMPTY_VAL : 32'(mem[rd_ptr]);
            ADDR_STATUS: rd_word = {ovf, full, empty, mode, 19'b0, 9'(count)};
            ADDR_VLED:   rd_word = {16'b0, vled_q};
            ADDR_HELLO:  rd_word = hello_world_q;
            ADDR_CTRL:   rd_word = {29'b0, 1'b0, 1'b0, mode};
            default:     rd_word = UNIMPL_VAL;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (rd_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end
    end

endmodule

// File: tb/tb_ocl_adder_fifo_bridge.sv
// Directed bench for ocl_adder_fifo_bridge: hand-computed results, a result queue, and
// boundary steps around full/flush, read hold and mid-read reset.
module tb_ocl_adder_fifo_bridge;

    localparam logic [31:0] A_HELLO  = 32'h0000_0500;
    localparam logic [31:0] A_VLED   = 32'h0000_0504;
    localparam logic [31:0] A_OPND   = 32'h0000_0510;
    localparam logic [31:0] A_RESULT = 32'h0000_0514;
    localparam logic [31:0] A_STATUS = 32'h0000_0518;
    localparam logic [31:0] A_CTRL   = 32'h0000_051C;

    logic        clk_main_a0;
    logic        rst_main_n_sync;
    logic [31:0] wr_addr;
    logic        wready;
    logic [31:0] wdata;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        rready;
    logic [15:0] vled_q;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] hello_world_q;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_val;

    ocl_adder_fifo_bridge dut (
        .clk_main_a0     (clk_main_a0),
        .rst_main_n_sync (rst_main_n_sync),
        .wr_addr         (wr_addr),
        .wready          (wready),
        .wdata           (wdata),
        .arvalid_q       (arvalid_q),
        .araddr_q        (araddr_q),
        .rready          (rready),
        .vled_q          (vled_q),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .rresp           (rresp),
        .hello_world_q   (hello_world_q)
    );

    // clock / reset
    initial begin
        clk_main_a0 = 1'b0;
        forever #5 clk_main_a0 = ~clk_main_a0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks: entered and left on a falling edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        wr_addr = addr;
        wdata   = data;
        wready  = 1'b1;
        @(negedge clk_main_a0);
        wready  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_main_a0);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        araddr_q  = addr;
        arvalid_q = 1'b1;
        rready    = 1'b1;
        @(negedge clk_main_a0);
        arvalid_q = 1'b0;
        for (int i = 0; i < 8 && !rvalid; i++) @(negedge clk_main_a0);
        check("rd_rvalid", {31'b0, rvalid}, 32'h1);
        data = rdata;
        @(negedge clk_main_a0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        check(tag, d, exp);
    endtask

    task automatic rd_result(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_0000;
        rd(A_RESULT, d);
        check(tag, d, e);
    endtask

    initial begin
        rst_main_n_sync = 1'b0;
        wr_addr = '0; wready = 1'b0; wdata = '0;
        arvalid_q = 1'b0; araddr_q = '0; rready = 1'b1;
        vled_q = 16'hA5C3;
        #1;
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rresp", {30'b0, rresp}, 32'h0);
        check("reset_hello", hello_world_q, 32'h0);
        idle(3);
        rst_main_n_sync = 1'b1;
        idle(1);

        rd_check("status_reset", A_STATUS, 32'h2000_0000);
        rd_check("result_empty", A_RESULT, 32'hDEAD_0000);

        wr(A_HELLO, 32'h1234_5678);
        check("hello_port", hello_world_q, 32'h1234_5678);
        rd_check("hello_read", A_HELLO, 32'h1234_5678);
        rd_check("vled_read", A_VLED, 32'h0000_A5C3);
        rd_check("ctrl_reset", A_CTRL, 32'h0000_0000);
        rd_check("opnd_unreadable", A_OPND, 32'hDEAD_BEEF);

        // add 7+15; first STATUS read is captured before the push lands, second after
        wr(A_OPND, 32'h0000_00F7);
        exp_q.push_back(32'h0000_0016);
        rd_check("status_before_push", A_STATUS, 32'h2000_0000);
        rd_check("status_after_push", A_STATUS, 32'h0000_0001);
        rd_result("add_7_15");

        // subtract 3-5 = -2 in 5 bits
        wr(A_CTRL, 32'h1);
        rd_check("ctrl_mode1", A_CTRL, 32'h0000_0001);
        wr(A_OPND, 32'h0000_0053);
        exp_q.push_back(32'h0000_001E);
        idle(3);
        rd_check("status_sub", A_STATUS, 32'h1000_0001);
        rd_result("sub_3_5");

        // mode change right behind an operand keeps the operand's sampled mode (1-2=-1)
        wr(A_OPND, 32'h0000_0021);
        wr(A_CTRL, 32'h0);
        exp_q.push_back(32'h0000_001F);
        idle(3);
        rd_result("sub_inflight");
        rd_check("ctrl_mode0", A_CTRL, 32'h0000_0000);

        // nine back-to-back pushes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            wr_addr = A_OPND; wdata = 32'h11; wready = 1'b1;
            @(negedge clk_main_a0);
        end
        wready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h2);
        idle(3);
        rd_check("status_ovf_full", A_STATUS, 32'hC000_0008);
        for (int i = 0; i < 8; i++) rd_result("ovf_drain");
        rd_check("status_drained", A_STATUS, 32'hA000_0000);
        rd_result("drained_empty");
        wr(A_CTRL, 32'h2);
        rd_check("status_ovf_clr", A_STATUS, 32'h2000_0000);

        // fill with distinct sums 2i+1, then push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) begin
            wr_addr = A_OPND; wdata = 32'((i + 1) << 4 | i); wready = 1'b1;
            exp_q.push_back(32'(2 * i + 1));
            @(negedge clk_main_a0);
        end
        wready = 1'b0;
        idle(3);
        rd_check("status_full", A_STATUS, 32'h4000_0008);
        wr(A_OPND, 32'h0000_0065);
        idle(1);
        rd_result("pushpop_head");
        exp_q.push_back(32'h0000_000B);
        rd_check("status_pushpop", A_STATUS, 32'h4000_0008);
        for (int i = 0; i < 8; i++) rd_result("wrap_order");
        rd_check("status_wrap_empty", A_STATUS, 32'h2000_0000);

        // flush in the same cycle as a push into a full FIFO
        for (int i = 0; i < 8; i++) begin
            wr_addr = A_OPND; wdata = 32'h11; wready = 1'b1;
            @(negedge clk_main_a0);
        end
        wready = 1'b0;
        idle(3);
        rd_check("status_full2", A_STATUS, 32'h4000_0008);
        wr(A_OPND, 32'h0000_0011);
        idle(1);
        wr(A_CTRL, 32'h4);
        idle(3);
        rd_check("status_flush", A_STATUS, 32'h2000_0000);
        rd_result("flush_empty");

        // read hold with rready low and repeated arvalid_q
        wr(A_OPND, 32'h0000_0032);
        wr(A_OPND, 32'h0000_0044);
        idle(3);
        araddr_q = A_RESULT; arvalid_q = 1'b1; rready = 1'b0;
        @(negedge clk_main_a0);
        for (int k = 0; k < 5; k++) begin
            check("hold_rvalid", {31'b0, rvalid}, 32'h1);
            check("hold_rdata", rdata, 32'h0000_0005);
            arvalid_q = (k % 2 == 0);
            @(negedge clk_main_a0);
        end
        arvalid_q = 1'b0; rready = 1'b1;
        @(negedge clk_main_a0);
        check("release_rvalid", {31'b0, rvalid}, 32'h0);
        check("release_rdata", rdata, 32'h0);
        rd_check("status_hold", A_STATUS, 32'h0000_0001);
        exp_q.push_back(32'h0000_0008);
        rd_result("after_hold");
        rd_check("unmapped", 32'h0000_0600, 32'hDEAD_BEEF);

        // reset asserted while a read is held and an operand is in flight
        wr(A_HELLO, 32'hCAFE_F00D);
        wr(A_CTRL, 32'h1);
        araddr_q = A_STATUS; arvalid_q = 1'b1; rready = 1'b0;
        @(negedge clk_main_a0);
        arvalid_q = 1'b0;
        wr_addr = A_OPND; wdata = 32'h11; wready = 1'b1;
        @(negedge clk_main_a0);
        wready = 1'b0;
        check("held_before_reset", {31'b0, rvalid}, 32'h1);
        rst_main_n_sync = 1'b0;
        #1;
        check("midreset_rvalid", {31'b0, rvalid}, 32'h0);
        check("midreset_rdata", rdata, 32'h0);
        check("midreset_hello", hello_world_q, 32'h0);
        rready = 1'b1;
        idle(2);
        rst_main_n_sync = 1'b1;
        idle(4);
        rd_check("status_after_reset", A_STATUS, 32'h2000_0000);
        rd_check("ctrl_after_reset", A_CTRL, 32'h0000_0000);
        rd_result("result_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ocl_adder_fifo_bridge.md
# ocl_adder_fifo_bridge

OCL register-slave front end for a parametrised adder/subtractor with a result FIFO, the next generation of the single 4-bit adder bridge in the CL. Host writes packed operand pairs. Each write is computed through a registered arithmetic stage and queued into a FIFO of configurable depth. Host reads pop results one per read, with status, mode control, overflow detection and flush, alongside the existing hello-world and VLED registers.

## Interface
- OPND_W, 4: operand width in bits; legal 1..15, so both operands fit in one 32-bit write.
- FIFO_DEPTH, 8: result FIFO entries; power of two, 2..256.
- ADDR_HELLO, 32'h0000_0500: hello-world scratch register.
- ADDR_VLED, 32'h0000_0504: VLED readback.
- ADDR_OPND, 32'h0000_0510: operand push (write-only).
- ADDR_RESULT, 32'h0000_0514: result pop (read-only).
- ADDR_STATUS, 32'h0000_0518: status (read-only).
- ADDR_CTRL, 32'h0000_051C: control (read/write).
- UNIMPL_VAL, 32'hDEAD_BEEF: read data for unmapped addresses.
- EMPTY_VAL, 32'hDEAD_0000: read data for a RESULT read while the FIFO is empty.
- clk_main_a0 in 1: single clock, all logic rising-edge.
- rst_main_n_sync in 1: reset, asynchronous, active-low.
- wr_addr in 32: write address, qualified by wready.
- wready in 1: write strobe, one write per cycle high.
- wdata in 32: write data.
- arvalid_q in 1: read request.
- araddr_q in 32: read address, valid with arvalid_q.
- rready in 1: host accepts read data.
- vled_q in 16: VLED value.
- rvalid out 1: read data valid.
- rdata out 32: read data.
- rresp out 2: always 2'b00.
- hello_world_q out 32: hello-world register.

## Operation
- Reset (async assert, sync release):
  - Outputs: rvalid=0, rdata=0, rresp=0, hello_world_q=0.
  - Internal: FIFO empty, count=0, mode=0 (add), ovf=0, pipeline valid=0.
- HELLO write: hello_world_q <= wdata.
- OPND write:
  - Fields: a=wdata[OPND_W-1:0], b=wdata[2*OPND_W-1:OPND_W]; higher bits ignored.
  - Stage 1 latches a, b and the current mode, and sets v1.
  - Stage 2 computes r (OPND_W+1 bits) and sets v2.
  - add: r = a + b, with the carry in bit OPND_W.
  - sub: r = a - b, two's complement modulo 2^(OPND_W+1); bit OPND_W set means borrow.
  - When v2 is set, r is pushed into the FIFO.
- CTRL write:
  - bit0 sets mode.
  - bit1=1 clears ovf.
  - bit2=1 flushes the FIFO: count=0 and pointers reset.
  - Mode is sampled per operand at stage 1, so a mode change never affects operands already in flight.
- CTRL read: {29'b0, 1'b0, 1'b0, mode}.
- Push while full, without a same-cycle pop: result dropped, ovf set (sticky).
- Push and pop in the same cycle: both succeed, count unchanged; this includes the full case, which does not set ovf.
- Flush in the same cycle as a push or pop: flush wins, the pushed result is discarded, ovf unchanged.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Read accept: when arvalid_q=1 and rvalid=0, the read is captured; rvalid=1 and rdata are valid on the next cycle.
- Read data by address:
  - RESULT, non-empty: zero-extended FIFO head; the entry is popped at capture.
  - RESULT, empty: EMPTY_VAL, no pop.
  - STATUS: {ovf, full, empty, mode, 19'b0, count[8:0]}.
  - VLED: {16'b0, vled_q}.
  - HELLO: hello_world_q.
  - CTRL: control word as above.
  - Any other address: UNIMPL_VAL.
- Read hold: rvalid and rdata hold until rvalid&rready. The cycle after, rvalid=0 and rdata=0. arvalid_q while rvalid=1 is ignored, with no pop and no capture.

## Timing
- OPND write in cycle N: v1 in N+1, push at the N+2 edge. count is visible to a read captured in N+3 or later.
- Back-to-back OPND writes: one push per cycle, with no bubbles.
- Read latency: capture in cycle N, rvalid=1 in N+1. The minimum read turnaround is 2 cycles, assuming rready is high in N+1.
- STATUS is sampled at the capture edge, before any same-cycle push or pop takes effect.
- Reset asserted mid-operation: in-flight operands and FIFO contents are lost immediately. No push occurs after release.

## Test plan
- Reset then read STATUS -> 32'h2000_0000 (empty=1, count=0); read RESULT -> 32'hDEAD_0000.
- Add: OPND_W=4, mode=0, write 32'h0000_00F7 (a=7, b=15), wait 3 cycles, read RESULT -> 32'h0000_0016.
- Subtract: set CTRL=1, write 32'h0000_0053 (a=3, b=5), read RESULT -> 32'h0000_001E (-2 in 5 bits). STATUS bit28=1.
- Overflow: FIFO_DEPTH=8, nine back-to-back OPND writes of 32'h11 -> STATUS 32'hC000_0008 (ovf, full, count=8). Eight RESULT reads -> 32'h2 each. Write CTRL=2 -> ovf=0.
- Boundary conditions, FIFO full:
  - Issue a RESULT read captured in the same cycle as a push -> count stays 8, ovf stays 0.
  - Write CTRL=4 in the same cycle as a push -> count=0, empty=1.
- Handshake: hold rready=0 for 5 cycles -> rvalid and rdata stable, no extra pop. Assert arvalid_q repeatedly meanwhile -> count unchanged. Unmapped address 32'h600 -> 32'hDEAD_BEEF. Assert reset mid-read -> rvalid=0 immediately.
